// File: rtl/video_mnist_cnn_param_ctl.sv
// Wishbone parameter shadow/apply controller for the video MNIST CNN pipeline.
// Applies shadow parameters at input frame starts and captures per-frame classifier results.
module video_mnist_cnn_param_ctl #(
  parameter int                  WB_ADR_WIDTH   = 8,
  parameter int                  WB_DAT_WIDTH   = 32,
  parameter int                  WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int                  TUSER_WIDTH    = 1,
  parameter int                  TNUMBER_WIDTH  = 4,
  parameter int                  TCOUNT_WIDTH   = 4,
  parameter logic [31:0]         CORE_ID        = 32'h527a_2310,
  parameter logic [7:0]          INIT_PARAM_TH  = 8'd127,
  parameter logic                INIT_PARAM_INV = 1'b0,
  parameter logic [3:0]          INIT_BLANK_NUM = 4'd3
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
  input  logic                     s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
  input  logic                     s_wb_stb_i,
  output logic                     s_wb_ack_o,

  input  logic [TUSER_WIDTH-1:0]   s_mon_tuser,
  input  logic                     s_mon_tvalid,
  input  logic                     s_mon_tready,

  input  logic [TUSER_WIDTH-1:0]   m_mon_tuser,
  input  logic                     m_mon_tlast,
  input  logic [TNUMBER_WIDTH-1:0] m_mon_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  m_mon_tcount,
  input  logic                     m_mon_tvalid,
  input  logic                     m_mon_tready,

  output logic [7:0]               param_th,
  output logic                     param_inv,
  output logic [3:0]               param_blank_num,
  output logic                     irq
);

  localparam logic [WB_ADR_WIDTH-1:0] ADR_ID        = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'(8'h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS    = WB_ADR_WIDTH'(8'h02);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_APPLY_CNT = WB_ADR_WIDTH'(8'h03);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_TH     = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_INV    = WB_ADR_WIDTH'(8'h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_SH_BLANK  = WB_ADR_WIDTH'(8'h06);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_RES_NUM   = WB_ADR_WIDTH'(8'h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_RES_CNT   = WB_ADR_WIDTH'(8'h09);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAME_CNT = WB_ADR_WIDTH'(8'h0A);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACT_TH    = WB_ADR_WIDTH'(8'h10);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACT_INV   = WB_ADR_WIDTH'(8'h11);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ACT_BLANK = WB_ADR_WIDTH'(8'h12);

  logic                     ctl_req_q,    ctl_req_d;
  logic                     ctl_auto_q,   ctl_auto_d;
  logic [7:0]               apply_cnt_q,  apply_cnt_d;
  logic [7:0]               shadow_th_q,  shadow_th_d;
  logic                     shadow_inv_q, shadow_inv_d;
  logic [3:0]               shadow_blank_q, shadow_blank_d;
  logic [7:0]               active_th_q,  active_th_d;
  logic                     active_inv_q, active_inv_d;
  logic [3:0]               active_blank_q, active_blank_d;
  logic [TNUMBER_WIDTH-1:0] hold_num_q,   hold_num_d;
  logic [TCOUNT_WIDTH-1:0]  hold_cnt_q,   hold_cnt_d;
  logic [TNUMBER_WIDTH-1:0] result_num_q, result_num_d;
  logic [TCOUNT_WIDTH-1:0]  result_cnt_q, result_cnt_d;
  logic [15:0]              frame_cnt_q,  frame_cnt_d;
  logic                     irq_q,        irq_d;

  logic wr_en;
  logic in_frame_start;
  logic apply;
  logic out_beat;
  logic capture;
  logic [WB_DAT_WIDTH-1:0] rd_data;

  // Tlast, upper tuser bits and upper data/select bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_mon_tuser, m_mon_tuser, m_mon_tlast, s_wb_dat_i, s_wb_sel_i};

  assign wr_en          = s_wb_stb_i & s_wb_we_i & s_wb_sel_i[0];
  assign in_frame_start = s_mon_tvalid & s_mon_tready & s_mon_tuser[0];
  assign apply          = in_frame_start & (ctl_req_q | ctl_auto_q);
  assign out_beat       = m_mon_tvalid & m_mon_tready;
  assign capture        = out_beat & m_mon_tuser[0];

  always_comb begin
    ctl_req_d      = ctl_req_q;
    ctl_auto_d     = ctl_auto_q;
    apply_cnt_d    = apply_cnt_q;
    shadow_th_d    = shadow_th_q;
    shadow_inv_d   = shadow_inv_q;
    shadow_blank_d = shadow_blank_q;
    active_th_d    = active_th_q;
    active_inv_d   = active_inv_q;
    active_blank_d = active_blank_q;
    hold_num_d     = hold_num_q;
    hold_cnt_d     = hold_cnt_q;
    result_num_d   = result_num_q;
    result_cnt_d   = result_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    irq_d          = capture;

    // Apply first so a same-edge register write overrides the consumed request
    // and updates the shadow after its old value was taken.
    if (apply) begin
      active_th_d    = shadow_th_q;
      active_inv_d   = shadow_inv_q;
      active_blank_d = shadow_blank_q;
      ctl_req_d      = 1'b0;
      apply_cnt_d    = apply_cnt_q + 8'd1;
    end

    if (wr_en) begin
      unique case (s_wb_adr_i)
        ADR_CONTROL: begin
          if (s_wb_dat_i[0]) ctl_req_d = 1'b1;
          ctl_auto_d = s_wb_dat_i[1];
        end
        ADR_SH_TH:    shadow_th_d    = s_wb_dat_i[7:0];
        ADR_SH_INV:   shadow_inv_d   = s_wb_dat_i[0];
        ADR_SH_BLANK: shadow_blank_d = s_wb_dat_i[3:0];
        default: ;
      endcase
    end

    if (capture) begin
      result_num_d = hold_num_q;
      result_cnt_d = hold_cnt_q;
      frame_cnt_d  = frame_cnt_q + 16'd1;
    end
    if (out_beat) begin
      hold_num_d = m_mon_tnumber;
      hold_cnt_d = m_mon_tcount;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_req_q      <= 1'b0;
      ctl_auto_q     <= 1'b0;
      apply_cnt_q    <= 8'd0;
      shadow_th_q    <= INIT_PARAM_TH;
      shadow_inv_q   <= INIT_PARAM_INV;
      shadow_blank_q <= INIT_BLANK_NUM;
      active_th_q    <= INIT_PARAM_TH;
      active_inv_q   <= INIT_PARAM_INV;
      active_blank_q <= INIT_BLANK_NUM;
      hold_num_q     <= '0;
      hold_cnt_q     <= '0;
      result_num_q   <= '0;
      result_cnt_q   <= '0;
      frame_cnt_q    <= 16'd0;
      irq_q          <= 1'b0;
    end else begin
      ctl_req_q      <= ctl_req_d;
      ctl_auto_q     <= ctl_auto_d;
      apply_cnt_q    <= apply_cnt_d;
      shadow_th_q    <= shadow_th_d;
      shadow_inv_q   <= shadow_inv_d;
      shadow_blank_q <= shadow_blank_d;
      active_th_q    <= active_th_d;
      active_inv_q   <= active_inv_d;
      active_blank_q <= active_blank_d;
      hold_num_q     <= hold_num_d;
      hold_cnt_q     <= hold_cnt_d;
      result_num_q   <= result_num_d;
      result_cnt_q   <= result_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      irq_q          <= irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (s_wb_adr_i)
      ADR_ID:        rd_data = WB_DAT_WIDTH'(CORE_ID);
      ADR_CONTROL:   rd_data[1:0] = {ctl_auto_q, ctl_req_q};
      ADR_STATUS:    rd_data[0] = ctl_req_q;
      ADR_APPLY_CNT: rd_data[7:0] = apply_cnt_q;
      ADR_SH_TH:     rd_data[7:0] = shadow_th_q;
      ADR_SH_INV:    rd_data[0] = shadow_inv_q;
      ADR_SH_BLANK:  rd_data[3:0] = shadow_blank_q;
      ADR_RES_NUM:   rd_data[TNUMBER_WIDTH-1:0] = result_num_q;
      ADR_RES_CNT:   rd_data[TCOUNT_WIDTH-1:0] = result_cnt_q;
      ADR_FRAME_CNT: rd_data[15:0] = frame_cnt_q;
      ADR_ACT_TH:    rd_data[7:0] = active_th_q;
      ADR_ACT_INV:   rd_data[0] = active_inv_q;
      ADR_ACT_BLANK: rd_data[3:0] = active_blank_q;
      default:       rd_data = '0;
    endcase
  end

  assign s_wb_dat_o      = rd_data;
  assign s_wb_ack_o      = s_wb_stb_i;
  assign param_th        = active_th_q;
  assign param_inv       = active_inv_q;
  assign param_blank_num = active_blank_q;
  assign irq             = irq_q;

endmodule
